seq_mac_unsigned: RTL and testbench
===================================

Name: seq_mac_unsigned

Overview:
- Unsigned multiply-accumulate stage built around a radix-2 sequential shift-add multiplier core.
- Accepts operand pairs over a valid/ready handshake and forms each product in WIDTH iterations.
- Adds each product into a running accumulator; on a pair flagged last, presents the accumulated sum downstream over a second valid/ready handshake.
- Feeds dot-product and filter datapaths that consume multiplier results.

Parameters:
WIDTH, 4, operand width of M and Q (>=2)
ACC_W, 12, accumulator/result width (>=2*WIDTH)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair (high only in IDLE)
in_m  input  WIDTH  multiplicand, unsigned
in_q  input  WIDTH  multiplier, unsigned
in_last  input  1  pair is the final term of the current sum
out_valid  output  1  accumulated result valid
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  accumulated sum
out_ovf  output  1  sticky: some accumulate carried out of ACC_W bits

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. Reset has priority over all other inputs, including mid-operation.
  - Reset clears all state: FSM=IDLE, accumulator=0, ovf=0, iteration counter=0, datapath regs=0.
  - Reset outputs: in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
- FSM states: IDLE, MUL, ACC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch M=in_m, P={carry,hi}=0, lo=in_q, last_r=in_last, count=WIDTH; go to MUL.
- MUL, one iteration per cycle, exactly WIDTH cycles:
  - If lo[0]: {carry,hi} = hi + M.
  - Then shift {carry,hi,lo} right by one; count decrements.
  - Go to ACC when count reaches 0 on the current cycle.
  - in_ready=0 throughout.
- ACC, one cycle:
  - {c,acc} = acc + zero-extended product {hi,lo} (2*WIDTH bits).
  - Sum wraps modulo 2^ACC_W; ovf |= c.
  - If last_r, go to OUT; else go to IDLE.
- OUT:
  - out_valid=1; out_acc=acc and out_ovf=ovf, held stable while out_ready=0.
  - in_ready=0: no new pairs are accepted until the result is taken.
  - On out_valid&out_ready: acc=0, ovf=0, go to IDLE, out_valid drops the next cycle.
- Timing, with the accept edge as cycle 0:
  - MUL occupies cycles 1..WIDTH; ACC occupies cycle WIDTH+1.
  - in_ready (non-last pair) or out_valid (last pair) is high from cycle WIDTH+2.
  - Throughput: one pair per WIDTH+2 cycles.
- out_acc and out_ovf are driven from registers at all times.
  - Both are valid only while out_valid=1.
  - Both read 0 after reset or after a result handshake, until the next accumulate.
- in_m, in_q and in_last are sampled only at the accept edge. Changes during MUL/ACC/OUT are ignored.
- Input and output handshakes never coincide, since in_ready=0 in OUT. in_valid may be asserted early and is held by the source until accepted.
- Zero operands (in_m=0 or in_q=0): the full WIDTH cycles still elapse; the product is 0.
- Maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits; the multiplier carry bit never remains set after the final shift.
- A single pair with in_last=1 yields out_acc = in_m*in_q.

Test Plan:
- WIDTH=4, ACC_W=12: pairs (3,5,last=0), (7,2,last=1), out_ready=1 -> out_valid in cycle 6 after second accept; out_acc=29, out_ovf=0; in_ready high 6 cycles after each accept.
- Single pair (15,15,last=1) -> out_acc=225; then (0,9,last=1) -> out_acc=0, proving accumulator cleared after handshake.
- ACC_W=8, pairs (15,15,0),(15,15,1) -> out_acc=194 (450 mod 256), out_ovf=1; next sum (1,1,1) -> out_acc=1, out_ovf=0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 and changing operands -> out_valid, out_acc, out_ovf stable, in_ready=0, no pair accepted; out_ready=1 -> handshake, IDLE next cycle.
- Reset mid-MUL (cycle 2 after accepting (9,9,1)) and reset in OUT -> next cycle in_ready=1, out_valid=0, out_acc=0, out_ovf=0; fresh pair (2,3,1) -> out_acc=6.
- Exhaustive 256 single-pair sums with random out_ready stalls -> each out_acc equals in_m*in_q against a reference model.

Source files
------------

// File: rtl/seq_mac_unsigned.sv
// seq_mac_unsigned: unsigned MAC built on a radix-2 shift-add multiplier, with valid/ready in and out
module seq_mac_unsigned #(
    parameter int WIDTH = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_q,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   add_w;
    logic [ACC_W:0]   sum_w;

    // The carry of hi+M is never stored: the shift moves it straight into hi's MSB.
    assign add_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign sum_w = {1'b0, acc_q} + {{(ACC_W + 1 - 2 * WIDTH){1'b0}}, hi_q, lo_q};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: accept, WIDTH shift-add iterations, one accumulate, then hold the result if last.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                m_d     = in_m;
                hi_d    = '0;
                lo_d    = in_q;
                last_d  = in_last;
                cnt_d   = CW'(WIDTH);
                state_d = MUL;
            end
            MUL: begin
                hi_d    = add_w[WIDTH:1];
                lo_d    = {add_w[0], lo_q[WIDTH-1:1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? ACC : MUL;
            end
            ACC: begin
                acc_d   = sum_w[ACC_W-1:0];
                ovf_d   = ovf_q | sum_w[ACC_W];
                state_d = last_q ? OUT : IDLE;
            end
            OUT: if (out_ready) begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_mac_unsigned.sv
// tb_seq_mac_unsigned: two widths of the MAC driven in lockstep and checked against a cycle-budget model
module tb_seq_mac_unsigned;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_m = '0;
    logic [3:0] in_q = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       rdy_a, ov_a, ovf_a, rdy_b, ov_b, ovf_b;
    logic [11:0] acc_a;
    logic [7:0]  acc_b;

    int errors = 0;
    int checks = 0;

    seq_mac_unsigned #(.WIDTH(W), .ACC_W(12)) ua (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_m(in_m), .in_q(in_q),
        .in_last(in_last), .out_valid(ov_a), .out_ready(out_ready), .out_acc(acc_a), .out_ovf(ovf_a)
    );

    seq_mac_unsigned #(.WIDTH(W), .ACC_W(8)) ub (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_m(in_m), .in_q(in_q),
        .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready), .out_acc(acc_b), .out_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pair costs WIDTH+1 busy cycles after acceptance, then its product lands in the sums.
    bit armed = 0;
    int busy = 0;
    bit outst = 0;
    bit p_last = 0;
    int prod = 0;
    int sa = 0, sb = 0;
    bit fa = 0, fb = 0;

    always @(posedge clk) begin
        armed = armed | rst;
        if (rst) begin
            busy = 0; outst = 0; sa = 0; sb = 0; fa = 0; fb = 0;
        end else if (outst) begin
            if (out_ready) begin
                outst = 0; sa = 0; sb = 0; fa = 0; fb = 0;
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                sa += prod;
                if (sa >= 4096) begin sa -= 4096; fa = 1; end
                sb += prod;
                if (sb >= 256) begin sb -= 256; fb = 1; end
                outst = p_last;
            end
        end else if (in_valid) begin
            prod   = int'(in_m) * int'(in_q);
            p_last = in_last;
            busy   = W + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready_a", rdy_a, (busy == 0 && !outst) ? 1 : 0);
            chk("out_valid_a", ov_a, outst ? 1 : 0);
            chk("out_acc_a", acc_a, sa);
            chk("out_ovf_a", ovf_a, fa ? 1 : 0);
            chk("in_ready_b", rdy_b, (busy == 0 && !outst) ? 1 : 0);
            chk("out_valid_b", ov_b, outst ? 1 : 0);
            chk("out_acc_b", acc_b, sb);
            chk("out_ovf_b", ovf_b, fb ? 1 : 0);
        end
    end

    task automatic send(input int m, input int q, input bit last);
        int n = 0;
        @(negedge clk);
        in_m = 4'(m); in_q = 4'(q); in_last = last; in_valid = 1'b1;
        while (!rdy_a && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", rdy_a, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_m = 4'($urandom); in_q = 4'($urandom); in_last = 1'($urandom);
    endtask

    task automatic get(input int ea, input int eo, input int eb, input int ebo, input int stall);
        int n = 0;
        while (!ov_a && n < 100) begin @(negedge clk); n++; end
        chk("result_wait", ov_a, 1);
        chk("lit_acc_a", acc_a, ea);
        chk("lit_ovf_a", ovf_a, eo);
        chk("lit_acc_b", acc_b, eb);
        chk("lit_ovf_b", ovf_b, ebo);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", rdy_a, 1);
        chk("rst_out_valid", ov_a, 0);
        chk("rst_out_acc", acc_a, 0);
        chk("rst_out_ovf", ovf_a, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", rdy_a, 1);
        chk("reset_out_valid", ov_a, 0);
        chk("reset_out_acc", acc_a, 0);
        chk("reset_out_ovf", ovf_a, 0);

        send(3, 5, 0);
        n = 1;
        while (!rdy_a && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_latency", n, 6);
        send(7, 2, 1);
        n = 1;
        while (!ov_a && n < 50) begin @(negedge clk); n++; end
        chk("out_valid_latency", n, 6);
        get(29, 0, 29, 0, 0);

        send(15, 15, 1);
        get(225, 0, 225, 0, 1);
        send(0, 9, 1);
        get(0, 0, 0, 0, 0);

        send(15, 15, 0);
        send(15, 15, 1);
        get(450, 0, 194, 1, 2);
        send(1, 1, 1);
        get(1, 0, 1, 0, 0);

        send(6, 7, 1);
        n = 0;
        while (!ov_a && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1;
        repeat (10) begin
            in_m = 4'($urandom); in_q = 4'($urandom); in_last = 1'($urandom);
            @(negedge clk);
            chk("bp_out_valid", ov_a, 1);
            chk("bp_out_acc", acc_a, 42);
            chk("bp_in_ready", rdy_a, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_release_idle", rdy_a, 1);
        chk("bp_release_valid", ov_a, 0);

        send(4, 4, 0);
        n = 0;
        while (!rdy_a && n < 50) begin @(negedge clk); n++; end
        chk("pre_reset_acc", acc_a, 16);
        send(9, 9, 1);
        pulse_reset();
        send(5, 5, 1);
        n = 0;
        while (!ov_a && n < 50) begin @(negedge clk); n++; end
        chk("out_before_reset", acc_a, 25);
        pulse_reset();
        send(2, 3, 1);
        get(6, 0, 6, 0, 0);

        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                send(m, q, 1);
                get(m * q, 0, m * q, 0, int'($urandom_range(0, 3)));
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
